// File: rtl/bin_search_guesser.sv
// Binary-search guesser: drives guesses to a magnitude comparator holding a
// secret, narrows [lo, hi] on each gt/lt response and reports the secret and
// the number of attempts once the comparator answers eq.
module bin_search_guesser #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    input  logic             resp_valid,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] attempts
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        ASK,
        UPDATE,
        DONE,
        ERR
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] lo, lo_d;
    logic [WIDTH-1:0] hi, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] attempts_q, attempts_d;

    // Midpoint on a WIDTH+1-bit sum so lo+hi never overflows.
    function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH:1];
    endfunction

    // Attempt counter saturates rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Search-window, guess, result and attempt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo         <= '0;
            hi         <= MAX_VAL;
            guess_q    <= '0;
            result_q   <= '0;
            attempts_q <= '0;
        end else begin
            lo         <= lo_d;
            hi         <= hi_d;
            guess_q    <= guess_d;
            result_q   <= result_d;
            attempts_q <= attempts_d;
        end
    end

    // Next-state and datapath updates; a response is only consumed in ASK.
    always_comb begin
        state_d    = state;
        lo_d       = lo;
        hi_d       = hi;
        guess_d    = guess_q;
        result_d   = result_q;
        attempts_d = attempts_q;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    lo_d       = '0;
                    hi_d       = MAX_VAL;
                    attempts_d = '0;
                    guess_d    = midpoint('0, MAX_VAL);
                    state_d    = ASK;
                end
            end
            ASK: begin
                if (resp_valid) begin
                    attempts_d = sat_inc(attempts_q);
                    if (!$onehot({gt, eq, lt})) begin
                        state_d = ERR;
                    end else if (eq) begin
                        result_d = guess_q;
                        state_d  = DONE;
                    end else if (gt) begin
                        if (guess_q == MAX_VAL) begin
                            state_d = ERR;
                        end else begin
                            lo_d    = guess_q + ONE_VAL;
                            state_d = UPDATE;
                        end
                    end else begin
                        if (guess_q == '0) begin
                            state_d = ERR;
                        end else begin
                            hi_d    = guess_q - ONE_VAL;
                            state_d = UPDATE;
                        end
                    end
                end
            end
            UPDATE: begin
                // An empty window means the responder contradicted itself.
                if (lo > hi) begin
                    state_d = ERR;
                end else begin
                    guess_d = midpoint(lo, hi);
                    state_d = ASK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign guess       = guess_q;
    assign guess_valid = (state == ASK);
    assign busy        = (state == ASK) || (state == UPDATE);
    assign done        = (state == DONE);
    assign error       = (state == ERR);
    assign result      = result_q;
    assign attempts    = attempts_q;

endmodule

// File: tb/tb_bin_search_guesser.sv
// Directed bench for bin_search_guesser (WIDTH=4): hand-computed guess
// sequences, results and attempt counts for a set of responder behaviours.
module tb_bin_search_guesser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] guess;
    logic       guess_valid;
    logic       resp_valid = 1'b0;
    logic       gt = 1'b0;
    logic       eq = 1'b0;
    logic       lt = 1'b0;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] result;
    logic [2:0] attempts;

    int n_assert = 0;
    int n_fail   = 0;

    bin_search_guesser #(.WIDTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .guess      (guess),
        .guess_valid(guess_valid),
        .resp_valid (resp_valid),
        .gt         (gt),
        .eq         (eq),
        .lt         (lt),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .result     (result),
        .attempts   (attempts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start from IDLE/DONE/ERR and check the first guess is presented.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_gv", 32'(guess_valid), 1);
        chk("start_guess", 32'(guess), 7);
        chk("start_attempts", 32'(attempts), 0);
        chk("start_done", 32'(done), 0);
        chk("start_error", 32'(error), 0);
    endtask

    // Wait for a guess, check it, optionally stall the response, then answer.
    task automatic step(input logic [3:0] exp_g, input int exp_wait, input int dly,
                        input logic g, input logic e, input logic l);
        int waited;
        waited = 0;
        @(negedge clk);
        while (guess_valid !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        chk("guess_wait", 32'(waited), 32'(exp_wait));
        chk("guess_val", 32'(guess), 32'(exp_g));
        if (dly > 0) begin
            resp_valid = 1'b0;
            gt = 1'b0; eq = 1'b0; lt = 1'b0;
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                chk("hold_gv", 32'(guess_valid), 1);
                chk("hold_guess", 32'(guess), 32'(exp_g));
            end
        end
        resp_valid = 1'b1;
        gt = g; eq = e; lt = l;
        @(posedge clk);
        #1;
        chk("gv_drop", 32'(guess_valid), 0);
        if (dly > 0) begin
            resp_valid = 1'b0;
            gt = 1'b0; eq = 1'b0; lt = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gv", 32'(guess_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_guess", 32'(guess), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_attempts", 32'(attempts), 0);
        rst = 1'b0;

        // Secret 11, resp_valid tied high
        resp_valid = 1'b1;
        do_start();
        step(4'd7, 0, 0, 1'b1, 1'b0, 1'b0);
        step(4'd11, 1, 0, 1'b0, 1'b1, 1'b0);
        chk("s11_done", 32'(done), 1);
        chk("s11_result", 32'(result), 11);
        chk("s11_attempts", 32'(attempts), 2);
        chk("s11_error", 32'(error), 0);
        chk("s11_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("s11_hold_done", 32'(done), 1);
        chk("s11_hold_result", 32'(result), 11);

        // Secret 0
        do_start();
        step(4'd7, 0, 0, 1'b0, 1'b0, 1'b1);
        step(4'd3, 1, 0, 1'b0, 1'b0, 1'b1);
        step(4'd1, 1, 0, 1'b0, 1'b0, 1'b1);
        step(4'd0, 1, 0, 1'b0, 1'b1, 1'b0);
        chk("s0_done", 32'(done), 1);
        chk("s0_result", 32'(result), 0);
        chk("s0_attempts", 32'(attempts), 4);

        // Secret 15
        do_start();
        step(4'd7, 0, 0, 1'b1, 1'b0, 1'b0);
        step(4'd11, 1, 0, 1'b1, 1'b0, 1'b0);
        step(4'd13, 1, 0, 1'b1, 1'b0, 1'b0);
        step(4'd14, 1, 0, 1'b1, 1'b0, 1'b0);
        step(4'd15, 1, 0, 1'b0, 1'b1, 1'b0);
        chk("s15_done", 32'(done), 1);
        chk("s15_result", 32'(result), 15);
        chk("s15_attempts", 32'(attempts), 5);

        // gt and lt together at the first guess
        do_start();
        step(4'd7, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("gtlt_error", 32'(error), 1);
        chk("gtlt_done", 32'(done), 0);
        chk("gtlt_attempts", 32'(attempts), 1);

        // Responder always gt: error after guess 15
        do_start();
        step(4'd7, 0, 0, 1'b1, 1'b0, 1'b0);
        step(4'd11, 1, 0, 1'b1, 1'b0, 1'b0);
        step(4'd13, 1, 0, 1'b1, 1'b0, 1'b0);
        step(4'd14, 1, 0, 1'b1, 1'b0, 1'b0);
        step(4'd15, 1, 0, 1'b1, 1'b0, 1'b0);
        chk("allgt_error", 32'(error), 1);
        chk("allgt_done", 32'(done), 0);
        chk("allgt_attempts", 32'(attempts), 5);

        // Responder always lt: error after guess 0
        do_start();
        step(4'd7, 0, 0, 1'b0, 1'b0, 1'b1);
        step(4'd3, 1, 0, 1'b0, 1'b0, 1'b1);
        step(4'd1, 1, 0, 1'b0, 1'b0, 1'b1);
        step(4'd0, 1, 0, 1'b0, 1'b0, 1'b1);
        chk("alllt_error", 32'(error), 1);
        chk("alllt_attempts", 32'(attempts), 4);

        // Contradictory responder empties the window: caught in UPDATE
        do_start();
        step(4'd7, 0, 0, 1'b1, 1'b0, 1'b0);
        step(4'd11, 1, 0, 1'b0, 1'b0, 1'b1);
        step(4'd9, 1, 0, 1'b0, 1'b0, 1'b1);
        step(4'd8, 1, 0, 1'b1, 1'b0, 1'b0);
        chk("incons_upd_busy", 32'(busy), 1);
        chk("incons_upd_error", 32'(error), 0);
        @(posedge clk);
        #1;
        chk("incons_error", 32'(error), 1);
        chk("incons_attempts", 32'(attempts), 4);

        // Secret 11 with responses delayed 3 cycles per guess
        resp_valid = 1'b0;
        gt = 1'b0; eq = 1'b0; lt = 1'b0;
        do_start();
        step(4'd7, 0, 3, 1'b1, 1'b0, 1'b0);
        step(4'd11, 1, 3, 1'b0, 1'b1, 1'b0);
        chk("dly_done", 32'(done), 1);
        chk("dly_result", 32'(result), 11);
        chk("dly_attempts", 32'(attempts), 2);
        chk("dly_error", 32'(error), 0);

        // Start while busy is ignored; reset mid-search aborts
        resp_valid = 1'b1;
        do_start();
        step(4'd7, 0, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resp_valid = 1'b0;
        gt = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_gv", 32'(guess_valid), 1);
        chk("busy_start_guess", 32'(guess), 11);
        chk("busy_start_attempts", 32'(attempts), 1);
        @(negedge clk);
        rst = 1'b1;
        resp_valid = 1'b1;
        eq = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_gv", 32'(guess_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_error", 32'(error), 0);
        chk("mid_rst_guess", 32'(guess), 0);
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_attempts", 32'(attempts), 0);
        rst = 1'b0;
        eq = 1'b0;

        // Fresh search for secret 5
        do_start();
        step(4'd7, 0, 0, 1'b0, 1'b0, 1'b1);
        step(4'd3, 1, 0, 1'b1, 1'b0, 1'b0);
        step(4'd5, 1, 0, 1'b0, 1'b1, 1'b0);
        chk("s5_done", 32'(done), 1);
        chk("s5_result", 32'(result), 5);
        chk("s5_attempts", 32'(attempts), 3);
        chk("s5_error", 32'(error), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_search_guesser.md
Name: bin_search_guesser

Overview:
- Initiator side of the magnitude-compare interface. It drives a guess operand to a comparator that holds a secret value, then consumes the comparator's one-hot greater/equal/less response.
- It runs a binary search over the unsigned range 0..2^WIDTH-1 and reports the secret value and the number of attempts used.
- It sits in the number-guessing datapath, opposite the comparator that sets the gt/eq/lt flags.

Parameters:
WIDTH, 4, bit width of the guess, the secret and the result
CNT_W, $clog2(WIDTH+2), width of the attempt counter (holds 0..WIDTH+1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a new search; sampled only in IDLE, DONE or ERR
guess  output  WIDTH  current guess driven to the comparator
guess_valid  output  1  guess is stable and awaiting a response
resp_valid  input  1  comparator response valid this cycle
gt  input  1  secret > guess
eq  input  1  secret == guess
lt  input  1  secret < guess
busy  output  1  high in ASK and UPDATE
done  output  1  search finished with eq; held until the next start
error  output  1  illegal or inconsistent response; held until the next start
result  output  WIDTH  secret value found; valid while done=1
attempts  output  CNT_W  number of responses consumed in the current or last search

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset state: state=IDLE, lo=0, hi=2^WIDTH-1, guess=0, guess_valid=0, busy=0, done=0, error=0, result=0, attempts=0.
- Reset mid-search: reset wins over every other event and aborts immediately. No response is consumed in the reset cycle.
- States: IDLE, ASK, UPDATE, DONE, ERR.
- IDLE/DONE/ERR with start=1:
  - next cycle lo=0, hi=2^WIDTH-1, attempts=0, done=0, error=0;
  - guess=(lo+hi)>>1 computed on a WIDTH+1-bit sum, which gives 2^(WIDTH-1)-1 initially;
  - state=ASK.
- ASK:
  - guess_valid=1; guess held stable;
  - stays in ASK while resp_valid=0 (no timeout).
- ASK with resp_valid=1, response consumed in that cycle:
  - attempts increments;
  - not exactly one of gt/eq/lt high -> ERR;
  - eq -> result=guess, DONE;
  - gt with guess==2^WIDTH-1 -> ERR; otherwise lo=guess+1, go to UPDATE;
  - lt with guess==0 -> ERR; otherwise hi=guess-1, go to UPDATE.
- guess_valid timing: drops to 0 the cycle after the response is consumed. One response is consumed per guess_valid episode.
- UPDATE (1 cycle):
  - if lo>hi -> ERR (inconsistent responder);
  - else guess=(lo+hi)>>1, state=ASK.
- Per-attempt latency: ASK wait plus 1 UPDATE cycle. With resp_valid tied high, a new guess appears every 2 cycles.
- Attempt bound: a consistent responder needs at most WIDTH+1 attempts. attempts never wraps.
- start while busy=1: ignored.
- start and resp_valid in the same cycle: only the state-appropriate one is acted on.
- DONE and ERR: outputs hold until start or rst.

Test Plan:
- WIDTH=4, secret 11, resp_valid tied high -> guesses 7 (gt), 11 (eq); done=1, result=11, attempts=2, error=0.
- Secret 0 -> guesses 7,3,1,0 all lt then eq; done=1, result=0, attempts=4. Secret 15 -> guesses 7,11,13,14,15; result=15, attempts=5.
- Response with gt=1 and lt=1 at the first guess 7 -> error=1, done=0, attempts=1. Responder always gt -> ERR after guess 15, attempts=5.
- resp_valid delayed 3 cycles per guess -> guess_valid held high and guess stable throughout the wait; same results as the tied-high case.
- rst asserted in ASK mid-search, and start pulsed while busy -> reset values restored the next cycle; the start pulse while busy is ignored. A new start afterwards completes a fresh search for secret 5 with result=5.
